// File: rtl/game_flow_controller.sv
// Frogger game-flow controller: start/run/death-freeze/level-up/game-over sequencing
// with lives and level bookkeeping. Every output is a register.
module game_flow_controller #(
  parameter int NUM_LIVES           = 3,
  parameter int MAX_LEVEL           = 9,
  parameter int DEATH_FREEZE_CYCLES = 25000000,
  parameter int LEVEL_PAUSE_CYCLES  = 12500000,
  parameter int LIVES_WIDTH         = 4,
  parameter int LEVEL_WIDTH         = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic                   i_Has_Collided,
  input  logic                   i_Reached_Goal,
  output logic                   o_Game_Active,
  output logic                   o_Freeze,
  output logic                   o_Frog_Reset,
  output logic                   o_Level_Up,
  output logic                   o_Game_Over,
  output logic [LEVEL_WIDTH-1:0] o_Level,
  output logic [LIVES_WIDTH-1:0] o_Lives,
  output logic [2:0]             o_State
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUNNING   = 3'd1,
    S_DYING     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam int MAX_CYC = (DEATH_FREEZE_CYCLES > LEVEL_PAUSE_CYCLES) ?
                           DEATH_FREEZE_CYCLES : LEVEL_PAUSE_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TIMER_W-1:0]     DEATH_LOAD = TIMER_W'(DEATH_FREEZE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     PAUSE_LOAD = TIMER_W'(LEVEL_PAUSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     TIMER_ONE  = TIMER_W'(1);
  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT = LIVES_WIDTH'(NUM_LIVES);
  localparam logic [LIVES_WIDTH-1:0] LIVES_ONE  = LIVES_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_TOP  = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE  = LEVEL_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   start_prev_q;
  logic                   start_evt;
  logic                   frog_reset_d;
  logic                   level_up_d;

  assign start_evt = i_Start & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    timer_d      = timer_q;
    frog_reset_d = 1'b0;
    level_up_d   = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_evt) begin
          state_d      = S_RUNNING;
          lives_d      = LIVES_INIT;
          level_d      = '0;
          frog_reset_d = 1'b1;
        end
      end
      S_RUNNING: begin
        // collision outranks the goal when both arrive together
        if (i_Has_Collided) begin
          if (lives_q > LIVES_ONE) begin
            lives_d = lives_q - LIVES_ONE;
            timer_d = DEATH_LOAD;
            state_d = S_DYING;
          end else begin
            lives_d = '0;
            state_d = S_GAME_OVER;
          end
        end else if (i_Reached_Goal) begin
          timer_d = PAUSE_LOAD;
          state_d = S_LEVEL_UP;
          if (level_q < LEVEL_TOP) begin
            level_d    = level_q + LEVEL_ONE;
            level_up_d = 1'b1;
          end
        end
      end
      S_DYING, S_LEVEL_UP: begin
        if (timer_q == '0) begin
          state_d      = S_RUNNING;
          frog_reset_d = 1'b1;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q       <= S_IDLE;
      lives_q       <= LIVES_INIT;
      level_q       <= '0;
      timer_q       <= '0;
      start_prev_q  <= 1'b1;
      o_Game_Active <= 1'b0;
      o_Freeze      <= 1'b0;
      o_Frog_Reset  <= 1'b0;
      o_Level_Up    <= 1'b0;
      o_Game_Over   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      timer_q       <= timer_d;
      start_prev_q  <= i_Start;
      o_Game_Active <= (state_d == S_RUNNING);
      o_Freeze      <= (state_d inside {S_DYING, S_LEVEL_UP, S_GAME_OVER});
      o_Frog_Reset  <= frog_reset_d;
      o_Level_Up    <= level_up_d;
      o_Game_Over   <= (state_d == S_GAME_OVER);
    end
  end

  assign o_State = state_q;
  assign o_Lives = lives_q;
  assign o_Level = level_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed vector table for the game scenarios,
// then randomized traffic against a behavioural model of the game rules.
module tb_game_flow_controller;

  localparam int NL = 3;
  localparam int ML = 2;
  localparam int DC = 4;
  localparam int PC = 2;

  logic       i_Clk = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Start = 1'b1;
  logic       i_Has_Collided = 1'b0;
  logic       i_Reached_Goal = 1'b0;
  logic       o_Game_Active, o_Freeze, o_Frog_Reset, o_Level_Up, o_Game_Over;
  logic [3:0] o_Level, o_Lives;
  logic [2:0] o_State;

  always #5 i_Clk = ~i_Clk;

  game_flow_controller #(
    .NUM_LIVES(NL), .MAX_LEVEL(ML), .DEATH_FREEZE_CYCLES(DC),
    .LEVEL_PAUSE_CYCLES(PC), .LIVES_WIDTH(4), .LEVEL_WIDTH(4)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start),
    .i_Has_Collided(i_Has_Collided), .i_Reached_Goal(i_Reached_Goal),
    .o_Game_Active(o_Game_Active), .o_Freeze(o_Freeze), .o_Frog_Reset(o_Frog_Reset),
    .o_Level_Up(o_Level_Up), .o_Game_Over(o_Game_Over), .o_Level(o_Level),
    .o_Lives(o_Lives), .o_State(o_State)
  );

  typedef struct {
    logic rst, st, col, gl;
    int   e_mode, e_lives, e_level;
    logic e_fr, e_lu;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model: mode uses the published o_State numbering, freeze_left counts remaining frozen cycles
  int   m_mode, m_lives, m_level, m_left;
  logic m_prev, m_fr, m_lu;

  function automatic logic [16:0] expect_vec(int mode, int lives, int level, logic fr, logic lu);
    logic act, frz, go;
    act = (mode == 1);
    frz = (mode == 2) || (mode == 3) || (mode == 4);
    go  = (mode == 4);
    return {3'(mode), act, frz, fr, lu, go, 4'(level), 4'(lives)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {o_State, o_Game_Active, o_Freeze, o_Frog_Reset, o_Level_Up, o_Game_Over, o_Level, o_Lives};
  endfunction

  function automatic void add(logic r, logic s, logic c, logic g, int md, int lv, int lvl, logic fr, logic lu);
    vec_t v;
    v.rst = r; v.st = s; v.col = c; v.gl = g;
    v.e_mode = md; v.e_lives = lv; v.e_level = lvl; v.e_fr = fr; v.e_lu = lu;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic s, input logic c, input logic g);
    i_Reset = r; i_Start = s; i_Has_Collided = c; i_Reached_Goal = g;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [16:0] exp);
    logic [16:0] got;
    got = dut_vec();
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got {st,act,frz,fr,lu,go,lvl,lives}=%b expected %b", name, idx, got, exp);
    end
  endtask

  function automatic void model_step(logic r, logic s, logic c, logic g);
    logic start_evt;
    if (r) begin
      m_mode = 0; m_lives = NL; m_level = 0; m_left = 0;
      m_prev = 1'b1; m_fr = 1'b0; m_lu = 1'b0;
      return;
    end
    start_evt = s && !m_prev;
    m_prev = s;
    m_fr = 1'b0;
    m_lu = 1'b0;
    if (m_mode == 0 || m_mode == 4) begin
      if (start_evt) begin
        m_mode = 1; m_lives = NL; m_level = 0; m_fr = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (c) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_mode = 4;
        else begin m_mode = 2; m_left = DC; end
      end else if (g) begin
        m_mode = 3; m_left = PC;
        if (m_level < ML) begin m_level++; m_lu = 1'b1; end
      end
    end else if (m_mode == 2 || m_mode == 3) begin
      m_left--;
      if (m_left == 0) begin m_mode = 1; m_fr = 1'b1; end
    end else begin
      m_mode = 0;
    end
  endfunction

  initial begin
    logic s_cur, r, c, g;

    // reset with start held, then held start must not launch a game
    add(1, 1, 0, 0, 0, 3, 0, 0, 0);
    add(1, 1, 0, 0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 1, i[0], i[1], 0, 3, 0, 0, 0);
    add(0, 0, 1, 1, 0, 3, 0, 0, 0);
    add(0, 1, 0, 0, 1, 3, 0, 1, 0);
    add(0, 1, 0, 0, 1, 3, 0, 0, 0);
    // first death with collision held through the freeze
    add(0, 1, 1, 0, 2, 2, 0, 0, 0);
    add(0, 1, 1, 0, 2, 2, 0, 0, 0);
    add(0, 1, 1, 1, 2, 2, 0, 0, 0);
    add(0, 1, 0, 0, 2, 2, 0, 0, 0);
    add(0, 1, 0, 0, 1, 2, 0, 1, 0);
    add(0, 1, 0, 0, 1, 2, 0, 0, 0);
    // second death, then last life lost
    add(0, 1, 1, 0, 2, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 2, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 1, 0);
    add(0, 1, 1, 0, 4, 0, 0, 0, 0);
    add(0, 1, 1, 1, 4, 0, 0, 0, 0);
    add(0, 0, 0, 0, 4, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 3, 0, 1, 0);
    // three goals: level 1, 2, then saturates at 2 without a pulse
    add(0, 1, 0, 1, 3, 3, 1, 0, 1);
    add(0, 1, 0, 1, 3, 3, 1, 0, 0);
    add(0, 1, 0, 0, 1, 3, 1, 1, 0);
    add(0, 1, 0, 1, 3, 3, 2, 0, 1);
    add(0, 1, 0, 0, 3, 3, 2, 0, 0);
    add(0, 1, 0, 0, 1, 3, 2, 1, 0);
    add(0, 1, 0, 1, 3, 3, 2, 0, 0);
    add(0, 1, 0, 0, 3, 3, 2, 0, 0);
    add(0, 1, 0, 0, 1, 3, 2, 1, 0);
    // simultaneous collision and goal, then reset on the second dying cycle
    add(0, 1, 1, 1, 2, 2, 2, 0, 0);
    add(1, 1, 0, 0, 0, 3, 0, 0, 0);
    add(0, 1, 0, 0, 0, 3, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].col, tbl[i].gl);
      check("table", i, expect_vec(tbl[i].e_mode, tbl[i].e_lives, tbl[i].e_level, tbl[i].e_fr, tbl[i].e_lu));
    end

    s_cur = 1'b1;
    drive(1, s_cur, 0, 0);
    model_step(1, s_cur, 0, 0);
    check("random_reset", 0, expect_vec(m_mode, m_lives, m_level, m_fr, m_lu));
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(199) == 0);
      if ($urandom_range(11) == 0) s_cur = ~s_cur;
      c = ($urandom_range(9) == 0);
      g = ($urandom_range(7) == 0);
      drive(r, s_cur, c, g);
      model_step(r, s_cur, c, g);
      check("random", i, expect_vec(m_mode, m_lives, m_level, m_fr, m_lu));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
